// File: rtl/pl_exe_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Holds the operation encodings, the iteration count and the FSM state encoding.
package pl_exe_mdu_pkg;

   localparam int DATA_W = 32;
   localparam int ITER   = 32;
   localparam int CNT_W  = $clog2(ITER);

   typedef enum logic [2:0] {
      MOP_MUL    = 3'd0,
      MOP_MULH   = 3'd1,
      MOP_MULHSU = 3'd2,
      MOP_MULHU  = 3'd3,
      MOP_DIV    = 3'd4,
      MOP_DIVU   = 3'd5,
      MOP_REM    = 3'd6,
      MOP_REMU   = 3'd7
   } mop_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                 input logic              is_neg);
      return is_neg ? -x : x;
   endfunction

endpackage

// File: rtl/pl_exe_mdu_step.sv
// One iteration of the MDU datapath on unsigned magnitudes.
// i_div=0: shift-add multiply step; i_div=1: restoring divide step on remainder:quotient.
module pl_mdu_step
   import pl_exe_mdu_pkg::*;
(
   input  logic        i_div,
   input  logic [63:0] i_acc,
   input  logic [31:0] i_b,
   output logic [63:0] o_acc
);

   logic [32:0] w_sum;
   logic [32:0] w_rem;
   logic [31:0] w_diff;
   logic        w_ge;

   always_comb begin
      w_sum  = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_b} : 33'd0);
      // The shifted partial remainder needs 33 bits before the trial subtract.
      w_rem  = i_acc[63:31];
      w_ge   = (w_rem >= {1'b0, i_b});
      w_diff = w_rem[31:0] - i_b;
      if (i_div) begin
         o_acc = w_ge ? {w_diff, i_acc[30:0], 1'b1}
                      : {w_rem[31:0], i_acc[30:0], 1'b0};
      end else begin
         o_acc = {w_sum, i_acc[31:1]};
      end
   end

endmodule

// File: rtl/pl_exe_mdu.sv
// Iterative RV32M multiply/divide unit for the E stage: 32 iterations on magnitudes,
// sign fix-up and special-case mapping on completion, pipeline stall while busy.
module pl_exe_mdu
   import pl_exe_mdu_pkg::*;
(
   input  logic        clk,
   input  logic        clrn,
   input  logic        start,
   input  logic [2:0]  mop,
   input  logic [31:0] ea,
   input  logic [31:0] eb,
   input  logic        kill,
   output logic        stall,
   output logic        done,
   output logic [31:0] result
);

   state_e           r_state;
   state_e           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [63:0]      r_acc;
   logic [31:0]      r_opnd;
   mop_e             r_mop;
   logic             r_sa;
   logic             r_sb;

   logic             w_accept;
   logic             w_op_div;
   logic             w_sa;
   logic             w_sb;
   logic [63:0]      w_step;
   logic [63:0]      w_prod;
   logic [31:0]      w_q;
   logic [31:0]      w_r;

   function automatic logic [63:0] neg64_if(input logic [63:0] x, input logic n);
      return n ? -x : x;
   endfunction

   function automatic logic [31:0] neg32_if(input logic [31:0] x, input logic n);
      return n ? -x : x;
   endfunction

   assign w_accept = (r_state == S_IDLE) && start && !kill;
   assign w_op_div = mop[2];
   assign w_sa     = ea[31] && (mop != MOP_MULHU) && (mop != MOP_DIVU) && (mop != MOP_REMU);
   assign w_sb     = eb[31] && ((mop == MOP_MUL) || (mop == MOP_MULH) ||
                                (mop == MOP_DIV) || (mop == MOP_REM));

   pl_mdu_step u_step (
      .i_div (r_mop[2]),
      .i_acc (r_acc),
      .i_b   (r_opnd),
      .o_acc (w_step)
   );

   always_comb begin
      w_next = r_state;
      if (kill) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == CNT_W'(ITER - 1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Multiply keeps |ea| as the addend and |eb| in the low half; divide keeps |eb|
   // as the divisor and |ea| as the initial quotient bits.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_opnd  <= '0;
         r_mop   <= MOP_MUL;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_mop  <= mop_e'(mop);
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_cnt  <= '0;
            r_opnd <= w_op_div ? abs_val(eb, w_sb) : abs_val(ea, w_sa);
            r_acc  <= {32'd0, (w_op_div ? abs_val(ea, w_sa) : abs_val(eb, w_sb))};
         end else if (r_state == S_BUSY) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Divide by zero yields an all-ones quotient; the remainder path already returns ea.
   always_comb begin
      w_prod = neg64_if(r_acc, r_sa ^ r_sb);
      w_q    = (r_opnd == 32'd0) ? 32'hFFFF_FFFF : neg32_if(r_acc[31:0], r_sa ^ r_sb);
      w_r    = neg32_if(r_acc[63:32], r_sa);
      result = 32'd0;
      if (r_state == S_DONE) begin
         case (r_mop)
            MOP_MUL:                          result = w_prod[31:0];
            MOP_MULH, MOP_MULHSU, MOP_MULHU:  result = w_prod[63:32];
            MOP_DIV, MOP_DIVU:                result = w_q;
            default:                          result = w_r;
         endcase
      end
   end

   assign stall = clrn && (w_accept || (r_state == S_BUSY));
   assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_pl_exe_mdu.sv
// Self-checking bench for pl_exe_mdu: directed RV32M cases, flush/reset/back-to-back
// sequencing, and randomized operations against an arithmetic reference model.
module tb_pl_exe_mdu;

   logic        clk = 1'b0;
   logic        clrn;
   logic        start;
   logic [2:0]  mop;
   logic [31:0] ea;
   logic [31:0] eb;
   logic        kill;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int n_total = 0;
   int n_pass  = 0;

   pl_exe_mdu dut (
      .clk    (clk),
      .clrn   (clrn),
      .start  (start),
      .mop    (mop),
      .ea     (ea),
      .eb     (eb),
      .kill   (kill),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] as_v, au_v, bs_v, bu_v, p;
      int          ia, ib;
      as_v = {{32{a[31]}}, a};
      au_v = {32'd0, a};
      bs_v = {{32{b[31]}}, b};
      bu_v = {32'd0, b};
      ia   = $signed(a);
      ib   = $signed(b);
      p    = 64'd0;
      case (op)
         3'd0: begin p = as_v * bs_v; return p[31:0];  end
         3'd1: begin p = as_v * bs_v; return p[63:32]; end
         3'd2: begin p = as_v * bu_v; return p[63:32]; end
         3'd3: begin p = au_v * bu_v; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(ia % ib);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of BUSY cycle 0.
   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      start = 1'b1; mop = op; ea = a; eb = b;
      #1 check1({tag, "_stall_at_start"}, stall, 1'b1);
      @(negedge clk);
      start = 1'b0;
      mop = 3'($urandom); ea = $urandom; eb = $urandom;
   endtask

   task automatic busy_cycles(input int n, output logic ok);
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (!(stall === 1'b1 && done === 1'b0)) ok = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic quiet_cycles(input int n, output logic ok);
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (!(stall === 1'b0 && done === 1'b0 && result === 32'd0)) ok = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
      logic ok;
      launch(op, a, b, tag);
      busy_cycles(32, ok);
      check1({tag, "_busy32"}, ok, 1'b1);
      check1({tag, "_done"}, done, 1'b1);
      check1({tag, "_stall_in_done"}, stall, 1'b0);
      check({tag, "_result"}, result, exp);
      @(negedge clk);
      check1({tag, "_done_clear"}, done, 1'b0);
      check({tag, "_result_clear"}, result, 32'd0);
   endtask

   initial begin
      logic        ok;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      clrn = 1'b0; start = 1'b0; mop = 3'd0; ea = 32'd0; eb = 32'd0; kill = 1'b0;
      repeat (3) @(negedge clk);
      check1("reset_stall", stall, 1'b0);
      check1("reset_done", done, 1'b0);
      check("reset_result", result, 32'd0);
      clrn = 1'b1;
      @(negedge clk);

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3");
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
      run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu_min");
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu_m1x2");
      run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");
      run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7");
      run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, "div_m100_7");
      run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, "rem_m100_7");
      run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
      run_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by_zero");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow");

      // Flush during BUSY cycle 10.
      launch(3'd0, 32'd1234, 32'd5678, "kill");
      busy_cycles(10, ok);
      check1("kill_busy10", ok, 1'b1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check1("kill_idle_stall", stall, 1'b0);
      quiet_cycles(36, ok);
      check1("kill_no_done", ok, 1'b1);

      // kill has priority over start in IDLE.
      start = 1'b1; kill = 1'b1; mop = 3'd5; ea = 32'd9; eb = 32'd3;
      #1 check1("kill_vs_start_stall", stall, 1'b0);
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      quiet_cycles(36, ok);
      check1("kill_vs_start_no_done", ok, 1'b1);

      // Reset during BUSY cycle 20.
      launch(3'd4, 32'd1000, 32'd3, "rst");
      busy_cycles(20, ok);
      check1("rst_busy20", ok, 1'b1);
      clrn = 1'b0;
      #1;
      check1("rst_mid_stall", stall, 1'b0);
      check1("rst_mid_done", done, 1'b0);
      check("rst_mid_result", result, 32'd0);
      @(negedge clk);
      clrn = 1'b1;
      quiet_cycles(36, ok);
      check1("rst_no_done", ok, 1'b1);
      run_op(3'd7, 32'd1000, 32'd3, 32'd1, "after_reset");

      // Back-to-back: next instruction arrives while DONE, accepted the cycle after.
      launch(3'd0, 32'd300, 32'd11, "b2b_first");
      busy_cycles(32, ok);
      check1("b2b_first_busy32", ok, 1'b1);
      start = 1'b1; mop = 3'd5; ea = 32'd4000; eb = 32'd9;
      #1;
      check1("b2b_first_done", done, 1'b1);
      check("b2b_first_result", result, 32'd3300);
      check1("b2b_start_ignored_in_done", stall, 1'b0);
      @(negedge clk);
      check1("b2b_second_not_done", done, 1'b0);
      launch(3'd5, 32'd4000, 32'd9, "b2b_second");
      busy_cycles(32, ok);
      check1("b2b_second_busy32", ok, 1'b1);
      check1("b2b_second_done", done, 1'b1);
      check("b2b_second_result", result, 32'd444);
      @(negedge clk);

      // Randomized operations with corner operands mixed in.
      for (int k = 0; k < 48; k++) begin
         rop = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0: ra = 32'd0;
            1: ra = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'h8000_0000;
            2: rb = 32'hFFFF_FFFF;
            3: rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_op%0d", k, rop));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
